// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - serial line inputs and host-side character outputs of the receiver
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 i_baud_tick;
  logic                 i_rx;
  logic                 i_rx_en;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_busy;

  // receiver side
  modport master (
    input  i_baud_tick, i_rx, i_rx_en,
    output o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

  // host / line-driver side
  modport slave (
    output i_baud_tick, i_rx, i_rx_en,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receive sequencer with parity and stop-bit checking
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  uart_rx_ctrl_if.master  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 at_last;

  // Full-bit sample point: one whole bit after the previous check
  assign at_last = (tcnt == T_LAST);

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame sequencer: start qualification, mid-bit sampling, checks and character delivery
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= S_IDLE;
      tcnt             <= '0;
      bcnt             <= '0;
      shreg            <= '0;
      par_err          <= 1'b0;
      bus.o_data       <= '0;
      bus.o_valid      <= 1'b0;
      bus.o_parity_err <= 1'b0;
      bus.o_frame_err  <= 1'b0;
      bus.o_busy       <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      if (!bus.i_rx_en) begin
        // Abort: drop any partial character, host outputs keep their last values
        state      <= S_IDLE;
        tcnt       <= '0;
        bcnt       <= '0;
        bus.o_busy <= 1'b0;
      end else if (bus.i_baud_tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state      <= S_START;
              tcnt       <= '0;
              bus.o_busy <= 1'b1;
            end
          end
          S_START: begin
            if (tcnt == T_HALF) begin
              tcnt <= '0;
              if (!rx_s) begin
                state <= S_DATA;
                bcnt  <= '0;
              end else begin
                // Line went back high before mid start bit: treat as noise
                state      <= S_IDLE;
                bus.o_busy <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_DATA: begin
            if (at_last) begin
              tcnt  <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              bcnt  <= bcnt + 1'b1;
              if (bcnt == B_LAST) begin
                state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (at_last) begin
              tcnt    <= '0;
              par_err <= (^shreg) ^ rx_s ^ (PARITY_ODD != 0);
              state   <= S_STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_STOP: begin
            if (at_last) begin
              tcnt             <= '0;
              bus.o_valid      <= 1'b1;
              bus.o_data       <= shreg;
              bus.o_parity_err <= (PARITY_EN != 0) && par_err;
              bus.o_frame_err  <= ~rx_s;
              if (rx_s) begin
                state      <= S_IDLE;
                bus.o_busy <= 1'b0;
              end else begin
                // Line still low (break): must see it high before a new start
                state <= S_RECOVER;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_RECOVER: begin
            if (rx_s) begin
              state      <= S_IDLE;
              tcnt       <= '0;
              bus.o_busy <= 1'b0;
            end
          end
          default: begin
            state      <= S_IDLE;
            tcnt       <= '0;
            bus.o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl, no-parity and even-parity instances
module tb_uart_rx_ctrl;

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
  } exp_t;

  typedef struct {
    int         lane;
    logic [7:0] data;
    bit         pbit;
    bit         stop;
    logic [7:0] x_data;
    bit         x_perr;
    bit         x_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_ctrl_if #(.DATA_BITS(8)) bus1 ();

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus0)
  );
  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int div    = 1;
  int phase  = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int vcount[2];
  int vcyc[2];
  logic prev_v[2];
  logic [9:0] prev_o[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int qsize(input int ln);
    return (ln == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Frame-level reference: even parity over data+parity bit, stop bit must be 1
  function automatic exp_t model(input logic [7:0] d, input bit has_par, input bit pbit, input bit stop);
    exp_t e;
    int ones;
    ones   = $countones(d) + int'(pbit);
    e.data = d;
    e.perr = has_par && (ones % 2 == 1);
    e.ferr = !stop;
    return e;
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
    cyc++;
    bus0.i_baud_tick = (phase == 0);
    bus1.i_baud_tick = (phase == 0);
    phase = (phase + 1) % div;
  endtask

  task automatic set_rx(input int ln, input logic b);
    if (ln == 0) bus0.i_rx = b;
    else bus1.i_rx = b;
  endtask

  task automatic send_bits(input int ln, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(ln, bits[i]);
      repeat (16 * div) clk_step();
    end
  endtask

  task automatic idle(input int ln, input int ticks);
    set_rx(ln, 1'b1);
    repeat (ticks * div) clk_step();
  endtask

  task automatic send_frame(input int ln, input logic [7:0] d, input bit pbit, input bit stop, input exp_t e);
    if (ln == 0) begin
      exp_q0.push_back(e);
      send_bits(0, {2'b00, stop, d, 1'b0}, 10);
    end else begin
      exp_q1.push_back(e);
      send_bits(1, {1'b0, stop, pbit, d, 1'b0}, 11);
    end
    idle(ln, 24);
  endtask

  task automatic mon_lane(input int ln, input logic v, input logic [9:0] o);
    exp_t e;
    chk("out_stable_without_valid", int'(!v && (o != prev_o[ln])), 0);
    if (v) begin
      chk("valid_one_cycle", int'(prev_v[ln]), 0);
      vcount[ln]++;
      vcyc[ln] = cyc;
      chk("valid_expected", int'(qsize(ln) > 0), 1);
      if (qsize(ln) > 0) begin
        e = (ln == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("o_data", int'(o[9:2]), int'(e.data));
        chk("o_parity_err", int'(o[1]), int'(e.perr));
        chk("o_frame_err", int'(o[0]), int'(e.ferr));
      end
    end
    prev_v[ln] = v;
    prev_o[ln] = o;
  endtask

  // Scoreboard: every o_valid is matched against the oldest expected character
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
      prev_o[0] = {bus0.o_data, bus0.o_parity_err, bus0.o_frame_err};
      prev_o[1] = {bus1.o_data, bus1.o_parity_err, bus1.o_frame_err};
    end else begin
      mon_lane(0, bus0.o_valid, {bus0.o_data, bus0.o_parity_err, bus0.o_frame_err});
      mon_lane(1, bus1.o_valid, {bus1.o_data, bus1.o_parity_err, bus1.o_frame_err});
    end
  end

  initial begin
    vec_t vt[7];
    exp_t e;
    int   t0;
    int   n0;
    int   ln;
    bit   busy_seen;
    logic [7:0] d;
    bit   pb;
    bit   sb;

    vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vt[2] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[3] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vt[5] = '{1, 8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[6] = '{1, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus0.i_rx = 1'b1;  bus1.i_rx = 1'b1;
    bus0.i_rx_en = 1'b1;  bus1.i_rx_en = 1'b1;
    bus0.i_baud_tick = 1'b1;  bus1.i_baud_tick = 1'b1;
    vcount[0] = 0;  vcount[1] = 0;
    vcyc[0] = 0;  vcyc[1] = 0;

    // Reset held while the line toggles
    for (int i = 0; i < 6; i++) begin
      bus0.i_rx = i[0];
      bus1.i_rx = i[0];
      clk_step();
    end
    chk("rst_o_valid", bus0.o_valid, 0);
    chk("rst_o_data", bus0.o_data, 0);
    chk("rst_o_parity_err", bus0.o_parity_err, 0);
    chk("rst_o_frame_err", bus0.o_frame_err, 0);
    chk("rst_o_busy", bus0.o_busy, 0);
    chk("rst_o_busy_par", bus1.o_busy, 0);
    bus0.i_rx = 1'b1;
    bus1.i_rx = 1'b1;
    clk_step();
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (20) begin
      clk_step();
      if (bus0.o_busy || bus1.o_busy) busy_seen = 1'b1;
    end
    chk("busy_after_release", busy_seen, 0);

    // Table-driven frames with fixed expected outputs and start-to-valid latency
    foreach (vt[k]) begin
      ln = vt[k].lane;
      t0 = cyc;
      n0 = vcount[ln];
      e  = '{vt[k].x_data, vt[k].x_perr, vt[k].x_ferr};
      send_frame(ln, vt[k].data, vt[k].pbit, vt[k].stop, e);
      chk("tbl_valid_count", vcount[ln] - n0, 1);
      chk("tbl_latency", vcyc[ln] - t0, 2 + 16 * (9 + ln) + 8 + 1);
      chk("tbl_drained", qsize(ln), 0);
    end

    // Glitch shorter than half a bit: busy pulses, nothing delivered
    n0 = vcount[0];
    set_rx(0, 1'b0);
    repeat (5) clk_step();
    chk("glitch_busy_high", bus0.o_busy, 1);
    set_rx(0, 1'b1);
    repeat (30) clk_step();
    chk("glitch_busy_low", bus0.o_busy, 0);
    chk("glitch_no_valid", vcount[0] - n0, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, model(8'h3C, 1'b0, 1'b0, 1'b1));
    chk("after_glitch_count", vcount[0] - n0, 1);

    // Stop bit low with line held low 64 ticks: one report, then RECOVER until line high
    n0 = vcount[0];
    exp_q0.push_back(model(8'h55, 1'b0, 1'b0, 1'b0));
    send_bits(0, {2'b00, 1'b0, 8'h55, 1'b0}, 10);
    repeat (48) clk_step();
    chk("recover_busy", bus0.o_busy, 1);
    chk("recover_one_valid", vcount[0] - n0, 1);
    idle(0, 24);
    chk("recover_exit", bus0.o_busy, 0);
    send_frame(0, 8'h0F, 1'b0, 1'b1, model(8'h0F, 1'b0, 1'b0, 1'b1));
    chk("after_break_count", vcount[0] - n0, 2);

    // Enable dropped during data bit 3
    n0 = vcount[0];
    send_bits(0, {2'b00, 1'b1, 8'hC3, 1'b0}, 4);
    set_rx(0, 1'b0);
    repeat (8) clk_step();
    bus0.i_rx_en = 1'b0;
    clk_step();
    chk("en_drop_idle", bus0.o_busy, 0);
    chk("en_drop_hold_data", bus0.o_data, 8'h0F);
    set_rx(0, 1'b1);
    repeat (40) clk_step();
    bus0.i_rx_en = 1'b1;
    idle(0, 8);
    chk("en_drop_no_valid", vcount[0] - n0, 0);

    // Async reset mid-frame
    send_bits(0, {2'b00, 1'b1, 8'hC3, 1'b0}, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus0.o_busy, 0);
    chk("midrst_data", bus0.o_data, 0);
    chk("midrst_valid", bus0.o_valid, 0);
    chk("midrst_ferr", bus0.o_frame_err, 0);
    chk("midrst_par_data", bus1.o_data, 0);
    chk("midrst_par_perr", bus1.o_parity_err, 0);
    repeat (3) clk_step();
    set_rx(0, 1'b1);
    rst_n = 1'b1;
    idle(0, 16);
    chk("midrst_no_valid", vcount[0] - n0, 0);
    send_frame(0, 8'hC3, 1'b0, 1'b1, model(8'hC3, 1'b0, 1'b0, 1'b1));
    chk("after_rst_count", vcount[0] - n0, 1);

    // Baud tick every 4th clock
    div = 4;
    phase = 0;
    idle(0, 4);
    n0 = vcount[0];
    send_frame(0, 8'h81, 1'b0, 1'b1, model(8'h81, 1'b0, 1'b0, 1'b1));
    chk("slow_tick_count", vcount[0] - n0, 1);
    div = 1;
    phase = 0;
    idle(0, 4);

    // Randomized frames on both instances against the frame-level model
    for (int i = 0; i < 24; i++) begin
      ln = i % 2;
      d  = 8'($urandom);
      pb = 1'($urandom_range(1));
      sb = ($urandom_range(3) != 0);
      n0 = vcount[ln];
      send_frame(ln, d, pb, sb, model(d, ln == 1, pb, sb));
      chk("rand_valid_count", vcount[ln] - n0, 1);
    end

    chk("final_drained", qsize(0) + qsize(1), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
